mem_responder: RTL and testbench

Main-memory responder at the far end of the cache-to-memory request interface. It accepts one request per cycle from the memory arbiter into a 4-bank, word-organised 16-bit memory. Each bank stays busy for a fixed latency after an access. Every accepted request returns exactly one in-order response, tagged so the result can be routed back to the I-cache or the D-cache.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_bank.sv | 70 +++++++
 rtl/mem_responder.sv | 144 ++++++++++++++
 tb/tb_mem_responder.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the main-memory responder.
//
// Contents:
//   DEFAULT_LATENCY : default access latency and bank busy time, in cycles
//   DEFAULT_MEM_AW  : default word-address width (2^MEM_AW words in total)
//   tag_e           : requester tag, TAG_I = I-cache, TAG_D = D-cache
//   mem_req_t       : packed request  {addr, rw, wdata, tag}
//   mem_rsp_t       : packed response {rdata, rw, tag, err}
package mem_pkg;

    localparam int DEFAULT_LATENCY = 4;
    localparam int DEFAULT_MEM_AW  = 10;

    typedef enum logic {
        TAG_I = 1'b0,
        TAG_D = 1'b1
    } tag_e;

    typedef struct packed {
        logic [15:0] addr;
        logic        rw;
        logic [15:0] wdata;
        tag_e        tag;
    } mem_req_t;

    typedef struct packed {
        logic [15:0] rdata;
        logic        rw;
        tag_e        tag;
        logic        err;
    } mem_rsp_t;

endpackage

// File: rtl/mem_bank.sv
// mem_bank: one word-organised bank of the main memory.
//
// Holds 2^(MEM_AW-2) 16-bit words and a busy counter. Once an access is
// accepted, the bank reports busy for LATENCY-1 further cycles.
//
// Ports:
//   clk    in  clock
//   rst    in  synchronous active-high reset (clears the busy counter only)
//   accept in  an access to this bank is accepted at this edge
//   row    in  row index inside the bank
//   rw     in  1 = write wdata into row at the accept edge
//   wdata  in  write data
//   busy   out bank cannot take a new access this cycle
//   rdata  out current contents of row (sampled by the top at accept)
module mem_bank
    import mem_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int MEM_AW  = DEFAULT_MEM_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic [MEM_AW-3:0] row,
    input  logic              rw,
    input  logic [15:0]       wdata,
    output logic              busy,
    output logic [15:0]       rdata
);

    localparam int         ROWS      = 1 << (MEM_AW - 2);
    localparam logic [3:0] BUSY_LOAD = 4'(LATENCY - 1);

    logic [15:0] mem_q [ROWS];
    logic [3:0]  busy_cnt_q;
    logic [3:0]  busy_cnt_d;
    logic        mem_we;

    // A fresh accept reloads the counter; otherwise it counts down to zero.
    // With LATENCY = 1 the load value is zero, so the bank never reports busy.
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (accept) begin
            busy_cnt_d = BUSY_LOAD;
        end else if (busy_cnt_q != 4'd0) begin
            busy_cnt_d = busy_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt_q <= 4'd0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign mem_we = accept & rw;

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[row] <= wdata;
        end
    end

    assign busy  = (busy_cnt_q != 4'd0);
    assign rdata = mem_q[row];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: main-memory responder at the far end of the cache-to-memory
// request interface. Four banks of 16-bit words, one accept per cycle, and a
// fixed-latency in-order response pipeline with no backpressure.
//
// Optional feature: define MEM_RESPONDER_ERR_EN to flag byte-misaligned
// accesses (addr[0] = 1) with rsp_err and suppress their array write. When it
// is not defined, addr[0] is ignored and rsp_err is always 0.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   mem_req_valid   request present
//   mem_req_ready   bank addressed by mem_req_addr can accept (never uses valid)
//   mem_req_addr    byte address; bank = addr[2:1], row = addr[MEM_AW:3]
//   mem_req_rw      1 = write, 0 = read
//   mem_req_wdata   write data
//   mem_req_tag     0 = I-cache, 1 = D-cache
//   rsp_valid       one-cycle response pulse, LATENCY cycles after accept
//   rsp_rdata       read data (0 for writes and flagged accesses)
//   rsp_rw, rsp_tag echoes of the request
//   rsp_err         misaligned-access flag
module mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int MEM_AW  = DEFAULT_MEM_AW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_valid,
    output logic        mem_req_ready,
    input  logic [15:0] mem_req_addr,
    input  logic        mem_req_rw,
    input  logic [15:0] mem_req_wdata,
    input  logic        mem_req_tag,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_rw,
    output logic        rsp_tag,
    output logic        rsp_err
);

    mem_req_t          req;
    logic [1:0]        bank_sel;
    logic [MEM_AW-3:0] row;
    logic              misaligned;
    logic              accept;
    logic [3:0]        bank_busy;
    logic [15:0]       bank_rdata [4];
    mem_rsp_t          stage0;

    logic [LATENCY-1:0] pipe_valid_q;
    logic [LATENCY-1:0] pipe_valid_d;
    mem_rsp_t           pipe_q [LATENCY];
    mem_rsp_t           pipe_d [LATENCY];

    assign req = '{addr:  mem_req_addr,
                   rw:    mem_req_rw,
                   wdata: mem_req_wdata,
                   tag:   tag_e'(mem_req_tag)};

    assign bank_sel = req.addr[2:1];
    assign row      = req.addr[MEM_AW:3];

    // Upper address bits are ignored on purpose, so the space wraps/aliases.
    generate
        if (MEM_AW < 15) begin : g_unused_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req.addr[15:MEM_AW+1];
        end
    endgenerate

    logic unused_addr_lsb;
    assign unused_addr_lsb = req.addr[0];

`ifdef MEM_RESPONDER_ERR_EN
    assign misaligned = req.addr[0];
`else
    assign misaligned = 1'b0;
`endif

    // Ready looks only at the addressed bank and reset, never at valid.
    assign mem_req_ready = ~rst & ~bank_busy[bank_sel];
    assign accept        = mem_req_valid & mem_req_ready;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_bank
            mem_bank #(
                .LATENCY (LATENCY),
                .MEM_AW  (MEM_AW)
            ) u_bank (
                .clk    (clk),
                .rst    (rst),
                .accept (accept && (bank_sel == 2'(g))),
                .row    (row),
                .rw     (req.rw & ~misaligned),
                .wdata  (req.wdata),
                .busy   (bank_busy[g]),
                .rdata  (bank_rdata[g])
            );
        end
    endgenerate

    // Response record captured at the accept edge. Idle slots carry zeros so
    // the rsp_* outputs read 0 whenever rsp_valid is low.
    always_comb begin
        stage0 = '0;
        if (accept) begin
            stage0.rw    = req.rw;
            stage0.tag   = req.tag;
            stage0.err   = misaligned;
            stage0.rdata = (req.rw || misaligned) ? 16'h0000 : bank_rdata[bank_sel];
        end
    end

    always_comb begin
        pipe_valid_d    = '0;
        pipe_valid_d[0] = accept;
        pipe_d[0]       = stage0;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_d[i]       = pipe_q[i-1];
        end
    end

    // Reset drops every in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_q       <= pipe_d;
        end
    end

    assign rsp_valid = pipe_valid_q[LATENCY-1];
    assign rsp_rdata = pipe_q[LATENCY-1].rdata;
    assign rsp_rw    = pipe_q[LATENCY-1].rw;
    assign rsp_tag   = pipe_q[LATENCY-1].tag;
    assign rsp_err   = pipe_q[LATENCY-1].err;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder (LATENCY 4, MEM_AW 10).
// Expectations come from a constant vector table and from a behavioural
// model (flat word array, per-bank free time, queue of due responses).
`timescale 1ns/1ps
module tb_mem_responder;
    import mem_pkg::*;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_req_addr;
    logic        mem_req_rw;
    logic [15:0] mem_req_wdata;
    logic        mem_req_tag;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_rw;
    logic        rsp_tag;
    logic        rsp_err;

    always #5 clk = ~clk;

    mem_responder #(
        .LATENCY (L),
        .MEM_AW  (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_rw    (mem_req_rw),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_tag   (mem_req_tag),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_rw        (rsp_rw),
        .rsp_tag       (rsp_tag),
        .rsp_err       (rsp_err)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    bit err_en;

    // Behavioural model state
    typedef struct {
        int          due;
        logic [15:0] rdata;
        bit          rdata_known;
        logic        rw;
        logic        tag;
        logic        err;
    } exp_rsp_t;

    exp_rsp_t    exp_q[$];
    int          bank_free [4];
    logic [15:0] model_mem [1024];
    bit          model_written [1024];

    // Last observed response
    bit          rsp_seen;
    int          rsp_cyc;
    logic [15:0] cap_rdata;
    logic        cap_rw;
    logic        cap_tag;
    logic        cap_err;

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [15:0] wdata;
        logic        tag;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    function automatic bit modelReady(input logic [15:0] a);
        return (rst !== 1'b1) && (bank_free[(int'(a) / 2) % 4] <= cyc + 1);
    endfunction

    task automatic modelAccept(input logic [15:0] a, input logic rw,
                               input logic [15:0] wd, input logic tag);
        exp_rsp_t e;
        int word;
        bit mis;
        word          = (int'(a) / 2) % 1024;
        mis           = err_en && (a % 2 == 1);
        e.due         = cyc + L - 1;
        e.rw          = rw;
        e.tag         = tag;
        e.err         = mis;
        e.rdata       = 16'h0000;
        e.rdata_known = 1'b1;
        if (rw) begin
            if (!mis) begin
                model_mem[word]     = wd;
                model_written[word] = 1'b1;
            end
        end else if (!mis) begin
            e.rdata       = model_mem[word];
            e.rdata_known = model_written[word];
        end
        bank_free[(int'(a) / 2) % 4] = cyc + L;
        exp_q.push_back(e);
    endtask

    // One clock cycle: drive the request, check ready, take the edge, then
    // check the response slot against the model.
    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic rw,
                                 input logic [15:0] wd, input logic tag,
                                 output bit seen_ready);
        bit exp_ready;
        bit accepted;
        exp_rsp_t e;
        mem_req_valid = v;
        mem_req_addr  = a;
        mem_req_rw    = rw;
        mem_req_wdata = wd;
        mem_req_tag   = tag;
        #1;
        exp_ready  = modelReady(a);
        seen_ready = mem_req_ready;
        checkOutput("mem_req_ready", 16'(mem_req_ready), 16'(exp_ready));
        accepted = v && exp_ready;
        @(posedge clk);
        cyc++;
        if (accepted) modelAccept(a, rw, wd, tag);
        #1;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            checkOutput("rsp_valid", 16'(rsp_valid), 16'h1);
            if (e.rdata_known) checkOutput("rsp_rdata", rsp_rdata, e.rdata);
            checkOutput("rsp_rw", 16'(rsp_rw), 16'(e.rw));
            checkOutput("rsp_tag", 16'(rsp_tag), 16'(e.tag));
            checkOutput("rsp_err", 16'(rsp_err), 16'(e.err));
        end else begin
            checkOutput("rsp_valid_idle", 16'(rsp_valid), 16'h0);
        end
        rsp_seen = (rsp_valid === 1'b1);
        if (rsp_seen) begin
            rsp_cyc   = cyc;
            cap_rdata = rsp_rdata;
            cap_rw    = rsp_rw;
            cap_tag   = rsp_tag;
            cap_err   = rsp_err;
        end
    endtask

    task automatic idle(input int n);
        bit r;
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, r);
    endtask

    task automatic doReset(input int n);
        rst           = 1'b1;
        mem_req_valid = 1'b0;
        exp_q.delete();
        bank_free     = '{default: 0};
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            cyc++;
            #1;
            checkOutput("reset_ready", 16'(mem_req_ready), 16'h0);
            checkOutput("reset_rsp_valid", 16'(rsp_valid), 16'h0);
            checkOutput("reset_rsp_rdata", rsp_rdata, 16'h0);
            checkOutput("reset_rsp_rw", 16'(rsp_rw), 16'h0);
            checkOutput("reset_rsp_tag", 16'(rsp_tag), 16'h0);
            checkOutput("reset_rsp_err", 16'(rsp_err), 16'h0);
        end
        rst = 1'b0;
    endtask

    // Issue one request, wait for its response, report latency and fields.
    task automatic doTxn(input logic [15:0] a, input logic rw, input logic [15:0] wd,
                         input logic tag, output bit got, output int lat);
        bit r;
        int n;
        int acc_cyc;
        n   = 0;
        got = 1'b0;
        lat = -1;
        do begin
            applyStimulus(1'b1, a, rw, wd, tag, r);
            n++;
        end while (!r && n < 20);
        mem_req_valid = 1'b0;
        if (!r) begin
            checkOutput("accept_timeout", 16'h0, 16'h1);
            return;
        end
        acc_cyc = cyc;
        if (rsp_seen && rsp_cyc == acc_cyc) got = 1'b1;
        n = 0;
        while (!got && n < L + 3) begin
            applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, r);
            n++;
            if (rsp_seen) got = 1'b1;
        end
        if (!got) checkOutput("response_timeout", 16'h0, 16'h1);
        else lat = rsp_cyc - acc_cyc + 1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected to finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit          r;
        bit          got;
        int          lat;
        int          stalls;
        int          seen_cnt;
        int          first_rsp;
        int          last_rsp;
        logic [15:0] ra;

`ifdef MEM_RESPONDER_ERR_EN
        err_en = 1'b1;
`else
        err_en = 1'b0;
`endif
        // addr, rw, wdata, tag, expected rdata, expected err
        vecs[0] = '{16'h0010, 1'b1, 16'hBEEF, 1'b1, 16'h0000, 1'b0};
        vecs[1] = '{16'h0010, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 1'b0};
        vecs[2] = '{16'h0800, 1'b1, 16'hA5A5, 1'b1, 16'h0000, 1'b0};
        vecs[3] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 16'hA5A5, 1'b0};
        vecs[4] = '{16'h0011, 1'b1, 16'h1234, 1'b1, 16'h0000, err_en};
        vecs[5] = '{16'h0010, 1'b0, 16'h0000, 1'b0, err_en ? 16'hBEEF : 16'h1234, 1'b0};

        mem_req_valid = 1'b0;
        mem_req_addr  = 16'h0;
        mem_req_rw    = 1'b0;
        mem_req_wdata = 16'h0;
        mem_req_tag   = 1'b0;
        bank_free     = '{default: 0};
        doReset(2);

        // Table: write/read-back, wrap/alias, misaligned access
        for (int i = 0; i < 6; i++) begin
            doTxn(vecs[i].addr, vecs[i].rw, vecs[i].wdata, vecs[i].tag, got, lat);
            if (got) begin
                checkOutput($sformatf("vec%0d_latency", i), 16'(lat), 16'(L));
                checkOutput($sformatf("vec%0d_rdata", i), cap_rdata, vecs[i].exp_rdata);
                checkOutput($sformatf("vec%0d_rw", i), 16'(cap_rw), 16'(vecs[i].rw));
                checkOutput($sformatf("vec%0d_tag", i), 16'(cap_tag), 16'(vecs[i].tag));
                checkOutput($sformatf("vec%0d_err", i), 16'(cap_err), 16'(vecs[i].exp_err));
            end
        end

        // Bank conflict: a second bank-0 request waits L-1 cycles
        applyStimulus(1'b1, 16'h0000, 1'b0, 16'h0, 1'b0, r);
        checkOutput("conflict_first_ready", 16'(r), 16'h1);
        stalls = 0;
        applyStimulus(1'b1, 16'h0008, 1'b0, 16'h0, 1'b1, r);
        while (!r && stalls < 20) begin
            stalls++;
            applyStimulus(1'b1, 16'h0008, 1'b0, 16'h0, 1'b1, r);
        end
        mem_req_valid = 1'b0;
        checkOutput("conflict_stall_cycles", 16'(stalls), 16'(L - 1));
        idle(L + 1);

        // Full throughput across the four banks
        for (int b = 0; b < 4; b++) begin
            doTxn(16'(2 * b), 1'b1, 16'h1100 + 16'(b), 1'b0, got, lat);
        end
        idle(L);
        seen_cnt  = 0;
        first_rsp = -1;
        last_rsp  = -1;
        for (int k = 0; k < 4 + L + 2; k++) begin
            if (k < 4) begin
                applyStimulus(1'b1, 16'(2 * k), 1'b0, 16'h0, k[0], r);
                checkOutput($sformatf("throughput_ready%0d", k), 16'(r), 16'h1);
            end else begin
                applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, r);
            end
            if (rsp_seen) begin
                seen_cnt++;
                if (first_rsp < 0) first_rsp = rsp_cyc;
                last_rsp = rsp_cyc;
            end
        end
        mem_req_valid = 1'b0;
        checkOutput("throughput_rsp_count", 16'(seen_cnt), 16'h4);
        checkOutput("throughput_rsp_span", 16'(last_rsp - first_rsp), 16'h3);

        // Reset mid-flight: response dropped, earlier write survives
        doTxn(16'h0020, 1'b1, 16'hCAFE, 1'b1, got, lat);
        idle(1);
        applyStimulus(1'b1, 16'h0020, 1'b0, 16'h0, 1'b0, r);
        checkOutput("midflight_accept", 16'(r), 16'h1);
        idle(1);
        doReset(2);
        seen_cnt = 0;
        for (int k = 0; k < L + 2; k++) begin
            applyStimulus(1'b0, 16'h0020, 1'b0, 16'h0, 1'b0, r);
            if (k == 0) checkOutput("ready_after_reset", 16'(r), 16'h1);
            if (rsp_seen) seen_cnt++;
        end
        checkOutput("midflight_dropped", 16'(seen_cnt), 16'h0);
        doTxn(16'h0020, 1'b0, 16'h0, 1'b0, got, lat);
        if (got) checkOutput("write_survives_reset", cap_rdata, 16'hCAFE);

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            ra = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
            applyStimulus($urandom_range(0, 3) != 0, ra, 1'($urandom), 16'($urandom),
                          1'($urandom), r);
        end
        mem_req_valid = 1'b0;
        idle(L + 2);
        checkOutput("random_drain", 16'(exp_q.size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
